rf_scoreboard: RTL and testbench
================================

# rf_scoreboard

Parametrised successor to the miniRV register file. It has N combinational read ports and one synchronous write-back port with same-cycle write-to-read bypass. A per-register busy scoreboard tracks outstanding producers, so issue logic can detect RAW hazards. It sits between decode/issue, which allocates destinations and reads operands, and write-back, which retires results and clears busy bits. The core uses it when moving from single-cycle to pipelined execution.

## Interface
Parameters:
- XLEN, 32, data width in bits
- NREGS, 16, number of architectural registers (power of two, ≥2)
- NRD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 is hard-wired zero, never written, never busy

Ports (AW = $clog2(NREGS)):
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rs_addr  in  NRD×AW  read-port register indices
- rs_data  out  NRD×XLEN  read data per port
- rs_busy  out  NRD  per-port "operand not yet produced"
- alloc_valid  in  1  issue: mark alloc_rd busy
- alloc_rd  in  AW  destination being issued
- wb_valid  in  1  write-back strobe
- wb_rd  in  AW  write-back destination
- wb_data  in  XLEN  write-back value
- flush  in  1  pipeline flush: clear all busy bits
- busy_cnt  out  AW+1  number of registers currently busy
- dbg_addr  in  AW  debug read index
- dbg_data  out  XLEN  debug read data (array value, no bypass)

## Operation
- Storage: NREGS×XLEN array plus a busy[NREGS] vector and busy_cnt register.
- Reset (rst_n low, async): all registers 0, all busy 0, busy_cnt 0. The outputs follow from this state.
- Read port i is combinational.
  - If ZERO_REG and rs_addr=0: rs_data=0, rs_busy=0.
  - Else if wb_valid and wb_rd=rs_addr: rs_data=wb_data (bypass), rs_busy=0.
  - Else: rs_data=array[rs_addr], rs_busy=busy[rs_addr].
- Write-back: if wb_valid and not (ZERO_REG and wb_rd=0), array[wb_rd]←wb_data and busy[wb_rd]←0.
- Allocate: if alloc_valid, not flush, and not (ZERO_REG and alloc_rd=0), busy[alloc_rd]←1.
- Allocate and write-back to the same register in the same cycle: allocate wins, so the bit stays/becomes busy. The data is still written.
- flush: all busy←0 next cycle. A concurrent write-back still writes data. A concurrent allocate is dropped.
- Allocating a register that is already busy is legal (WAW): the bit stays 1 and the count is unchanged.
- busy_cnt always equals popcount(busy). It is updated incrementally: +1 on a 0→1 transition, −1 on a 1→0 transition, net 0 when both occur. On flush it is set to 0.
- The scoreboard does not stall. Consumers must hold issue while any needed rs_busy=1.

## Timing
- Read latency: 0 cycles.
- Write visibility: same cycle via bypass, then from the array on the next cycle.
- Allocate: rs_busy rises on the cycle after alloc_valid.
- Write-back: rs_busy falls in the same cycle via bypass and stays low from the next edge.
- busy_cnt reflects the edge just taken, with 1-cycle latency after alloc/wb/flush.
- rst_n assertion mid-operation clears the array, busy and busy_cnt immediately, without waiting for a clock edge. Deassertion is synchronised externally.
- dbg_data is combinational from the array and carries no bypass.

## Structure
- Package rf_pkg holds:
  - the default XLEN/NREGS constants
  - typedef reg_idx_t (logic [AW-1:0])
  - typedef xdata_t (logic [XLEN-1:0])
  - function is_zero_reg(idx) honouring ZERO_REG
- Sub-module rf_busy_tracker: owns busy[], busy_cnt, the alloc/wb/flush priority and the count update. Its outputs are the busy vector and the count.
- The top level holds the data array, the bypass muxes (generate loop over NRD) and the debug port.

## Test plan
- Reset, then wb_valid rd=5 data=0xDEADBEEF. The same-cycle read of rs_addr=5 returns 0xDEADBEEF with rs_busy=0. The next-cycle dbg_addr=5 returns 0xDEADBEEF.
- wb_valid rd=0 data=0x1234 with ZERO_REG=1 → reads of register 0 return 0 forever. alloc_rd=0 → busy_cnt stays 0.
- alloc rd=3 → next cycle rs_busy=1, busy_cnt=1. Two cycles later, wb rd=3 data=7 → same cycle rs_busy=0, rs_data=7. Next cycle busy_cnt=0.
- alloc rd=4 and wb rd=4 data=9 in the same cycle with register 4 busy → register 4 stays busy, array holds 9, busy_cnt unchanged.
- alloc registers 1, 2, 3 on consecutive cycles → busy_cnt=3. Then flush together with alloc rd=6 → busy_cnt=0 and no register busy.
- Pull rst_n low mid-sequence with register 7=0x55 and busy → outputs go to 0 without waiting for a clock edge. After release, register 7 reads 0 and is not busy. Repeat the sequence with NRD=4 and all ports reading the same register.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared types and helpers for the scoreboarded register file.
package rf_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned NREGS_DEF = 16;
    localparam int unsigned AW_DEF    = $clog2(NREGS_DEF);

    typedef logic [AW_DEF-1:0]   reg_idx_t;
    typedef logic [XLEN_DEF-1:0] xdata_t;

    // True when idx names the hard-wired zero register.
    function automatic logic is_zero_reg(input logic zero_en, input int unsigned idx);
        return zero_en && (idx == 0);
    endfunction

endpackage

// File: rtl/rf_busy_tracker.sv
// Per-register busy bits and running popcount for RAW hazard detection.
module rf_busy_tracker
    import rf_pkg::*;
#(
    parameter int unsigned NREGS    = NREGS_DEF,
    parameter logic        ZERO_REG = 1'b1,
    localparam int unsigned AW      = $clog2(NREGS),
    localparam int unsigned CW      = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alloc_valid,
    input  logic [AW-1:0]    alloc_rd,
    input  logic             wb_valid,
    input  logic [AW-1:0]    wb_rd,
    input  logic             flush,
    output logic [NREGS-1:0] busy,
    output logic [CW-1:0]    busy_cnt
);

    logic [NREGS-1:0] busy_q, busy_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             set_en, clr_en, inc, dec;

    // Allocate beats write-back on the same register; flush beats both.
    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        set_en = alloc_valid && !is_zero_reg(ZERO_REG, 32'(alloc_rd));
        clr_en = wb_valid && !is_zero_reg(ZERO_REG, 32'(wb_rd));
        inc    = 1'b0;
        dec    = 1'b0;
        if (flush) begin
            busy_d = '0;
            cnt_d  = '0;
        end else begin
            if (clr_en) begin
                busy_d[wb_rd] = 1'b0;
            end
            if (set_en) begin
                busy_d[alloc_rd] = 1'b1;
            end
            inc   = set_en && !busy_q[alloc_rd];
            dec   = clr_en && busy_q[wb_rd] && !(set_en && (alloc_rd == wb_rd));
            cnt_d = cnt_q + CW'(inc) - CW'(dec);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy     = busy_q;
    assign busy_cnt = cnt_q;

endmodule

// File: rtl/rf_scoreboard.sv
// Register file with N bypassed read ports, one write-back port and busy scoreboard.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_DEF,
    parameter int unsigned NREGS    = NREGS_DEF,
    parameter int unsigned NRD      = 2,
    parameter logic        ZERO_REG = 1'b1,
    localparam int unsigned AW      = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rs_addr,
    output logic [NRD*XLEN-1:0] rs_data,
    output logic [NRD-1:0]      rs_busy,
    input  logic                alloc_valid,
    input  logic [AW-1:0]       alloc_rd,
    input  logic                wb_valid,
    input  logic [AW-1:0]       wb_rd,
    input  logic [XLEN-1:0]     wb_data,
    input  logic                flush,
    output logic [AW:0]         busy_cnt,
    input  logic [AW-1:0]       dbg_addr,
    output logic [XLEN-1:0]     dbg_data
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [NREGS-1:0] busy;
    logic             wb_en;

    rf_busy_tracker #(
        .NREGS    (NREGS),
        .ZERO_REG (ZERO_REG)
    ) u_busy (
        .clk         (clk),
        .rst_n       (rst_n),
        .alloc_valid (alloc_valid),
        .alloc_rd    (alloc_rd),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .flush       (flush),
        .busy        (busy),
        .busy_cnt    (busy_cnt)
    );

    // Write-back data lands regardless of flush or a concurrent allocate.
    always_comb begin
        regs_d = regs_q;
        wb_en  = wb_valid && !is_zero_reg(ZERO_REG, 32'(wb_rd));
        if (wb_en) begin
            regs_d[wb_rd] = wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    for (genvar i = 0; i < int'(NRD); i++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data_c;
        logic            busy_c;

        assign addr = rs_addr[i*AW +: AW];

        // Zero register first, then same-cycle bypass, then stored state.
        always_comb begin
            data_c = regs_q[addr];
            busy_c = busy[addr];
            if (is_zero_reg(ZERO_REG, 32'(addr))) begin
                data_c = '0;
                busy_c = 1'b0;
            end else if (wb_valid && (wb_rd == addr)) begin
                data_c = wb_data;
                busy_c = 1'b0;
            end
        end

        assign rs_data[i*XLEN +: XLEN] = data_c;
        assign rs_busy[i]              = busy_c;
    end

    assign dbg_data = regs_q[dbg_addr];

endmodule

// File: tb/tb_rf_scoreboard.sv
// Randomized and directed checks of rf_scoreboard against a behavioural model.
module tb_rf_scoreboard;
    import rf_pkg::*;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 16;
    localparam int unsigned NRD   = 4;
    localparam int unsigned AW    = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NRD*AW-1:0]   rs_addr;
    logic [NRD*XLEN-1:0] rs_data;
    logic [NRD-1:0]      rs_busy;
    logic                alloc_valid;
    logic [AW-1:0]       alloc_rd;
    logic                wb_valid;
    logic [AW-1:0]       wb_rd;
    logic [XLEN-1:0]     wb_data;
    logic                flush;
    logic [AW:0]         busy_cnt;
    logic [AW-1:0]       dbg_addr;
    logic [XLEN-1:0]     dbg_data;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] m_mem  [NREGS];
    bit          m_busy [NREGS];

    rf_scoreboard #(
        .XLEN     (XLEN),
        .NREGS    (NREGS),
        .NRD      (NRD),
        .ZERO_REG (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rs_addr     (rs_addr),
        .rs_data     (rs_data),
        .rs_busy     (rs_busy),
        .alloc_valid (alloc_valid),
        .alloc_rd    (alloc_rd),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .flush       (flush),
        .busy_cnt    (busy_cnt),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_count();
        int c = 0;
        for (int r = 0; r < int'(NREGS); r++) c += int'(m_busy[r]);
        return c;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < int'(NREGS); r++) begin
            m_mem[r]  = '0;
            m_busy[r] = 1'b0;
        end
    endtask

    task automatic model_update();
        if (wb_valid && wb_rd != 0) m_mem[wb_rd] = wb_data;
        if (flush) begin
            for (int r = 0; r < int'(NREGS); r++) m_busy[r] = 1'b0;
        end else begin
            if (wb_valid && wb_rd != 0) m_busy[wb_rd] = 1'b0;
            if (alloc_valid && alloc_rd != 0) m_busy[alloc_rd] = 1'b1;
        end
    endtask

    task automatic compare_all();
        for (int p = 0; p < int'(NRD); p++) begin
            logic [AW-1:0] a;
            logic [31:0]   ed;
            logic          eb;
            a = rs_addr[p*AW +: AW];
            if (a == 0) begin
                ed = 0; eb = 1'b0;
            end else if (wb_valid && wb_rd == a) begin
                ed = wb_data; eb = 1'b0;
            end else begin
                ed = m_mem[a]; eb = m_busy[a];
            end
            check($sformatf("rs_data%0d", p), rs_data[p*XLEN +: XLEN], ed);
            check($sformatf("rs_busy%0d", p), 32'(rs_busy[p]), 32'(eb));
        end
        check("busy_cnt", 32'(busy_cnt), 32'(model_count()));
        check("dbg_data", dbg_data, m_mem[dbg_addr]);
    endtask

    task automatic settle();
        #2;
        compare_all();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        alloc_valid = 1'b0; alloc_rd = '0;
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
        flush = 1'b0;
    endtask

    task automatic set_rs_all(input logic [AW-1:0] a);
        for (int p = 0; p < int'(NRD); p++) rs_addr[p*AW +: AW] = a;
        dbg_addr = a;
    endtask

    task automatic do_alloc(input logic [AW-1:0] r);
        idle();
        alloc_valid = 1'b1; alloc_rd = r;
    endtask

    task automatic do_wb(input logic [AW-1:0] r, input logic [31:0] d);
        idle();
        wb_valid = 1'b1; wb_rd = r; wb_data = d;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        set_rs_all('0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset state.
        set_rs_all(4'd9);
        settle();
        check("rst_cnt", 32'(busy_cnt), 0);
        advance();

        // Write-back bypass, then array visibility.
        do_wb(4'd5, 32'hDEADBEEF);
        set_rs_all(4'd5);
        settle();
        check("wb_bypass", rs_data[XLEN-1:0], 32'hDEADBEEF);
        advance();
        idle();
        settle();
        check("wb_dbg", dbg_data, 32'hDEADBEEF);
        advance();

        // Register 0 is immutable and never busy.
        do_wb(4'd0, 32'h1234);
        set_rs_all(4'd0);
        settle();
        advance();
        do_alloc(4'd0);
        settle();
        check("zero_data", rs_data[XLEN-1:0], 0);
        advance();
        idle();
        settle();
        check("zero_cnt", 32'(busy_cnt), 0);
        advance();

        // Allocate then retire register 3.
        do_alloc(4'd3);
        set_rs_all(4'd3);
        settle();
        advance();
        idle();
        settle();
        check("alloc_busy", 32'(rs_busy[0]), 1);
        check("alloc_cnt", 32'(busy_cnt), 1);
        advance();
        do_wb(4'd3, 32'd7);
        settle();
        check("wb3_busy", 32'(rs_busy[1]), 0);
        check("wb3_data", rs_data[XLEN +: XLEN], 7);
        advance();
        idle();
        settle();
        check("wb3_cnt", 32'(busy_cnt), 0);
        advance();

        // Allocate and write-back collide on a busy register.
        do_alloc(4'd4);
        set_rs_all(4'd4);
        settle();
        advance();
        alloc_valid = 1'b1; alloc_rd = 4'd4;
        wb_valid = 1'b1; wb_rd = 4'd4; wb_data = 32'd9;
        settle();
        advance();
        idle();
        settle();
        check("coll_busy", 32'(rs_busy[2]), 1);
        check("coll_data", dbg_data, 9);
        check("coll_cnt", 32'(busy_cnt), 1);
        advance();

        // Flush wins over a concurrent allocate.
        flush = 1'b1;
        settle();
        advance();
        for (int r = 1; r <= 3; r++) begin
            do_alloc(AW'(r));
            settle();
            advance();
        end
        idle();
        settle();
        check("three_cnt", 32'(busy_cnt), 3);
        do_alloc(4'd6);
        flush = 1'b1;
        set_rs_all(4'd6);
        settle();
        advance();
        idle();
        settle();
        check("flush_cnt", 32'(busy_cnt), 0);
        check("flush_busy", 32'(rs_busy), 0);
        advance();

        // Asynchronous reset mid-cycle.
        do_alloc(4'd7);
        wb_valid = 1'b1; wb_rd = 4'd7; wb_data = 32'h55;
        set_rs_all(4'd7);
        settle();
        advance();
        idle();
        settle();
        check("pre_rst_busy", 32'(rs_busy), 32'hF);
        check("pre_rst_dbg", dbg_data, 32'h55);
        #1 rst_n = 1'b0;
        #1 model_reset();
        check("arst_data", rs_data[31:0] | rs_data[63:32] | rs_data[95:64] | rs_data[127:96], 0);
        check("arst_busy", 32'(rs_busy), 0);
        check("arst_cnt", 32'(busy_cnt), 0);
        check("arst_dbg", dbg_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        settle();
        check("post_rst_data", rs_data[127:96], 0);
        check("post_rst_busy", 32'(rs_busy), 0);
        advance();

        // Randomized traffic over a narrow register range to force collisions.
        for (int c = 0; c < 600; c++) begin
            idle();
            alloc_valid = ($urandom_range(0, 1) == 1);
            alloc_rd    = AW'($urandom_range(0, 7));
            wb_valid    = ($urandom_range(0, 1) == 1);
            wb_rd       = AW'($urandom_range(0, 7));
            wb_data     = $urandom;
            flush       = ($urandom_range(0, 19) == 0);
            for (int p = 0; p < int'(NRD); p++) rs_addr[p*AW +: AW] = AW'($urandom_range(0, 9));
            dbg_addr = AW'($urandom_range(0, 15));
            settle();
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
